// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its CPU, DMA and SRAM neighbours.
// The slave modport is the arbiter's view of the bus; the master modport is the environment's view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic [1:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_lock;
  logic [1:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        mem_en;
  logic [1:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU memory stage and a DMA engine.
// Grants are made in the request cycle, and read data is routed back one cycle later.
module dmem_arbiter (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam logic [1:0] WE_READ   = 2'b00;
  localparam logic [2:0] BURST_MAX = 3'd4;

  owner_e     last_grant_q, last_grant_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic [2:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pending_q, rd_pending_d;

  logic        cpu_grant, dma_grant;
  logic [1:0]  gnt_we;
  logic [31:0] gnt_addr, gnt_wdata;

  // Under contention, a locked DMA may keep the port for up to four cycles in a row.
  always_comb begin
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (rst) begin
      if (bus.cpu_req && bus.dma_req) begin
        if (last_grant_q == OWN_CPU || (bus.dma_lock && burst_cnt_q < BURST_MAX))
          dma_grant = 1'b1;
        else
          cpu_grant = 1'b1;
      end else begin
        cpu_grant = bus.cpu_req;
        dma_grant = bus.dma_req;
      end
    end
  end

  always_comb begin
    gnt_we    = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (cpu_grant) begin
      gnt_we    = bus.cpu_we;
      gnt_addr  = bus.cpu_addr;
      gnt_wdata = bus.cpu_wdata;
    end else if (dma_grant) begin
      gnt_we    = bus.dma_we;
      gnt_addr  = bus.dma_addr;
      gnt_wdata = bus.dma_wdata;
    end
  end

  always_comb begin
    bus.mem_en     = cpu_grant | dma_grant;
    bus.mem_we     = gnt_we;
    bus.mem_addr   = gnt_addr;
    bus.mem_wdata  = gnt_wdata;
    bus.cpu_stall  = rst & bus.cpu_req & ~cpu_grant;
    bus.dma_gnt    = dma_grant;
    bus.cpu_rvalid = rd_pending_q & (rd_owner_q == OWN_CPU);
    bus.dma_rvalid = rd_pending_q & (rd_owner_q == OWN_DMA);
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (cpu_grant)
      last_grant_d = OWN_CPU;
    else if (dma_grant)
      last_grant_d = OWN_DMA;

    burst_cnt_d = '0;
    if (dma_grant)
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 3'd1;

    rd_pending_d = (cpu_grant | dma_grant) && (gnt_we == WE_READ);
    rd_owner_d   = rd_owner_q;
    if (rd_pending_d)
      rd_owner_d = dma_grant ? OWN_DMA : OWN_CPU;
  end

  // Reset leaves last_grant at DMA so the CPU wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_DMA;
      burst_cnt_q  <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWN_CPU;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all predicted
// by a transaction-level model (last winner, DMA run length, one-deep read-return slot).
module tb_dmem_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if bus ();

  dmem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  // Memory returns data one cycle after a read issue, and garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we == 2'b00)
      bus.mem_rdata <= mem_fn(bus.mem_addr);
    else
      bus.mem_rdata <= $urandom();
  end

  // Reference model state: 0 = CPU, 1 = DMA.
  int          m_last;
  int          m_run;
  bit          p_valid;
  int          p_owner;
  logic [31:0] p_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_run   = 0;
    p_valid = 1'b0;
    p_owner = 0;
    p_addr  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_en"},     32'(bus.mem_en),     32'h0);
    chk({tag, ".mem_we"},     32'(bus.mem_we),     32'h0);
    chk({tag, ".mem_addr"},   bus.mem_addr,        32'h0);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,       32'h0);
    chk({tag, ".cpu_stall"},  32'(bus.cpu_stall),  32'h0);
    chk({tag, ".dma_gnt"},    32'(bus.dma_gnt),    32'h0);
    chk({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'h0);
    chk({tag, ".dma_rvalid"}, 32'(bus.dma_rvalid), 32'h0);
    chk({tag, ".cpu_rdata"},  bus.cpu_rdata,       32'h0);
    chk({tag, ".dma_rdata"},  bus.dma_rdata,       32'h0);
  endtask

  // Hold reset for ncyc cycles with random requests active, then release with the bus idle.
  task automatic do_reset(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst           = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 2'($urandom_range(0, 3));
      bus.cpu_addr  = $urandom();
      bus.cpu_wdata = $urandom();
      bus.dma_req   = 1'b1;
      bus.dma_lock  = 1'($urandom_range(0, 1));
      bus.dma_we    = 2'($urandom_range(0, 3));
      bus.dma_addr  = $urandom();
      bus.dma_wdata = $urandom();
      #1;
      check_all_zero(tag);
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    rst         = 1'b1;
    model_reset();
  endtask

  task automatic step(input string tag,
                      input bit creq, input logic [1:0] cwe, input logic [31:0] caddr,
                      input logic [31:0] cwdata,
                      input bit dreq, input bit dlock, input logic [1:0] dwe,
                      input logic [31:0] daddr, input logic [31:0] dwdata);
    int          win;
    logic [1:0]  e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwdata;
    bus.dma_req   = dreq;
    bus.dma_lock  = dlock;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwdata;
    #1;
    if (creq && dreq)
      win = (m_last == 0 || (dlock && m_run < 4)) ? 1 : 0;
    else if (creq)
      win = 0;
    else if (dreq)
      win = 1;
    else
      win = -1;
    e_we    = (win == 0) ? cwe    : (win == 1) ? dwe    : 2'b00;
    e_addr  = (win == 0) ? caddr  : (win == 1) ? daddr  : 32'h0;
    e_wdata = (win == 0) ? cwdata : (win == 1) ? dwdata : 32'h0;

    chk({tag, ".mem_en"},     32'(bus.mem_en),     32'(win >= 0));
    chk({tag, ".mem_we"},     32'(bus.mem_we),     32'(e_we));
    chk({tag, ".mem_addr"},   bus.mem_addr,        e_addr);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,       e_wdata);
    chk({tag, ".cpu_stall"},  32'(bus.cpu_stall),  32'(creq && win != 0));
    chk({tag, ".dma_gnt"},    32'(bus.dma_gnt),    32'(win == 1));
    chk({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(p_valid && p_owner == 0));
    chk({tag, ".dma_rvalid"}, 32'(bus.dma_rvalid), 32'(p_valid && p_owner == 1));
    chk({tag, ".cpu_rdata"},  bus.cpu_rdata, (p_valid && p_owner == 0) ? mem_fn(p_addr) : 32'h0);
    chk({tag, ".dma_rdata"},  bus.dma_rdata, (p_valid && p_owner == 1) ? mem_fn(p_addr) : 32'h0);

    if (win >= 0) m_last = win;
    m_run   = (win == 1) ? m_run + 1 : 0;
    p_valid = (win >= 0) && (e_we == 2'b00);
    p_owner = win;
    p_addr  = e_addr;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_lock = 1'b0; bus.dma_we = '0; bus.dma_addr = '0;
    bus.dma_wdata = '0; bus.mem_rdata = '0;
    model_reset();

    do_reset("reset", 3);

    // First contention after reset goes to the CPU, then the DMA while the CPU stalls.
    step("first_both", 1'b1, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 2'b00, 32'h200, 32'h0);
    step("second_both", 1'b1, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 2'b00, 32'h200, 32'h0);
    idle("after_both");

    step("cpu_rd_10", 1'b1, 2'b00, 32'h10, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    idle("cpu_rd_10_ret");
    chk("deadbeef_path", mem_fn(32'h10), 32'hDEAD_BEEF);

    for (int i = 0; i < 12; i++)
      step("lock_burst", 1'b1, 2'b00, 32'h300, 32'h0, 1'b1, 1'b1, 2'b00, 32'h400 + 32'(i), 32'h0);
    idle("lock_end");

    for (int i = 0; i < 6; i++) begin
      step("alt_cpu", 1'b1, 2'b00, 32'h20, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      step("alt_dma", 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
    end
    idle("alt_end");

    step("dma_wr", 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h80, 32'h1234_5678);
    idle("dma_wr_after");

    // Reset lands while a CPU read is in flight; nothing may come back.
    step("cpu_rd_pre_rst", 1'b1, 2'b00, 32'h50, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    do_reset("mid_rst", 1);
    step("post_rst_both", 1'b1, 2'b00, 32'h60, 32'h0, 1'b1, 1'b0, 2'b00, 32'h70, 32'h0);
    idle("post_rst_idle");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0)
        do_reset("rand_rst", 1 + int'($urandom_range(0, 1)));
      else
        step("rand",
             $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 63)) << 2, $urandom(),
             $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 63)) << 2, $urandom());
    end
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
